// File: rtl/time_set_pkg.sv
// Shared definitions for the time-set button controller.
// Provides the mode/state encoding (RUN=0, SET_MIN=1, SET_HOUR=2), its width
// MODE_W, and the helper that advances the mode on a mode-button press.
package time_set_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    RUN      = 2'd0,
    SET_MIN  = 2'd1,
    SET_HOUR = 2'd2
  } state_t;

  // RUN -> SET_MIN -> SET_HOUR -> RUN
  function automatic state_t next_mode(input state_t s);
    case (s)
      RUN:     return SET_MIN;
      SET_MIN: return SET_HOUR;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   raw   - raw button input, asynchronous to clk
//   level - debounced button level
//   press - one-clock pulse on a debounced 0->1 transition
// The level only follows the synchronised input after it has differed for
// DEB_CYCLES consecutive clocks; any return to the old value restarts the count.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // press is registered together with the new level so the event
        // appears in the same cycle the debounced level rises
        level <= sync2;
        press <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Time-set controller: turns the mode/up/down push-buttons into set-enable
// levels and single-cycle up/down strobes for the minute/hour BCD chains.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   btn_mode/up/down      - raw active-high buttons
//   min_set_ena           - high while in SET_MIN
//   hr_set_ena            - high while in SET_HOUR
//   up, down              - one-clock strobes for the selected field
//   mode                  - current state (RUN=0, SET_MIN=1, SET_HOUR=2)
// Optional feature: define TIME_SET_AUTO_REPEAT_EN to auto-repeat strobes
// while a single up/down button stays held in a set mode.
module time_set_controller
  import time_set_pkg::*;
#(
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int REPEAT_DELAY   = 16,
  parameter int REPEAT_PERIOD  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic              min_set_ena,
  output logic              hr_set_ena,
  output logic              up,
  output logic              down,
  output logic [MODE_W-1:0] mode
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic mode_press, up_press, down_press;
  logic mode_level_unused, up_lvl, down_lvl;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clk), .rst(rst), .raw(btn_mode), .level(mode_level_unused), .press(mode_press)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst(rst), .raw(btn_up), .level(up_lvl), .press(up_press)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .rst(rst), .raw(btn_down), .level(down_lvl), .press(down_press)
  );

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             up_d, down_d;
  logic             rpt_fire;

  // Priority: mode press, then RUN hold, then up/down press, then repeat,
  // then timeout expiry, else keep counting idle clocks.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    if (mode_press) begin
      state_d = next_mode(state_q);
      tmo_d   = '0;
    end else if (state_q == RUN) begin
      tmo_d = '0;
    end else if (up_press || down_press) begin
      tmo_d  = '0;
      up_d   = up_press & ~down_press;
      down_d = down_press & ~up_press;
    end else if (rpt_fire) begin
      tmo_d  = '0;
      up_d   = up_lvl;
      down_d = down_lvl;
    end else if (tmo_q == TMO_LAST) begin
      state_d = RUN;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      tmo_q       <= '0;
      up          <= 1'b0;
      down        <= 1'b0;
      min_set_ena <= 1'b0;
      hr_set_ena  <= 1'b0;
      mode        <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      up          <= up_d;
      down        <= down_d;
      min_set_ena <= (state_d == SET_MIN);
      hr_set_ena  <= (state_d == SET_HOUR);
      mode        <= state_d;
    end
  end

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY) + 1;
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             arm_q, arm_d;
  logic             single_held;

  assign single_held = up_lvl ^ down_lvl;
  assign rpt_fire    = arm_q & single_held & (rpt_q == RPT_LAST);

  // Armed only by an accepted up/down strobe; disarmed by release, a second
  // held button or any state change. Reloading to DELAY-PERIOD after each
  // repeat gives the shorter period without a second counter.
  always_comb begin
    rpt_d = rpt_q;
    arm_d = arm_q;
    if (state_d != state_q || !single_held) begin
      rpt_d = '0;
      arm_d = 1'b0;
    end else if (up_press || down_press) begin
      rpt_d = '0;
      arm_d = up_d | down_d;
    end else if (arm_q) begin
      rpt_d = (rpt_q == RPT_LAST) ? RPT_RELOAD : rpt_q + RPT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q <= '0;
      arm_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
      arm_q <= arm_d;
    end
  end
`else
  logic rpt_unused;
  assign rpt_fire   = 1'b0;
  assign rpt_unused = ^{up_lvl, down_lvl, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: table-driven button vectors
// plus hand-written sequences (glitch, timeout, auto-repeat, reset), with a
// scoreboard of expected output events (strobes and mode changes).
module tb_time_set_controller;

  localparam int DEB  = 4;
  localparam int TMO  = 64;
  localparam int RDLY = 16;
  localparam int RPER = 4;
  localparam int LAT  = DEB + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       min_set_ena, hr_set_ena, up, down;
  logic [1:0] mode;

  time_set_controller #(
    .DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .min_set_ena(min_set_ena), .hr_set_ena(hr_set_ena), .up(up), .down(down), .mode(mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic       up;
    logic       down;
  } ev_t;

  typedef struct {
    logic       m;
    logic       u;
    logic       d;
    logic       ev;
    logic [1:0] mode;
    logic       up;
    logic       down;
  } vec_t;

  ev_t        sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         strobe_cnt = 0;
  logic [1:0] prev_mode = 2'd0;
  logic       mon_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input logic [1:0] m, input logic u, input logic d);
    ev_t e;
    e.cyc = c; e.mode = m; e.up = u; e.down = d;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Output monitor: every strobe or mode change must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (rst || !mon_en) begin
      prev_mode = 2'd0;
    end else begin
      check("invariants", int'(!(min_set_ena && hr_set_ena) && !(up && down) &&
            (min_set_ena == (mode == 2'd1)) && (hr_set_ena == (mode == 2'd2)) &&
            (!(up || down) || mode != 2'd0)), 1);
      if (up || down) strobe_cnt++;
      if (up || down || mode != prev_mode) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: cycle %0d mode=%0d up=%b down=%b, required no event",
                   cyc, mode, up, down);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.mode != mode || e.up != up || e.down != down) begin
            n_fail++;
            $display("FAIL event: got cycle %0d mode=%0d up=%b down=%b, required cycle %0d mode=%0d up=%b down=%b",
                     cyc, mode, up, down, e.cyc, e.mode, e.up, e.down);
          end
        end
      end
      prev_mode = mode;
    end
  end

  function automatic vec_t mk(input logic m, input logic u, input logic d, input logic ev,
                              input logic [1:0] md, input logic eu, input logic ed);
    vec_t v;
    v.m = m; v.u = u; v.d = d; v.ev = ev; v.mode = md; v.up = eu; v.down = ed;
    return v;
  endfunction

  // Press the given buttons cleanly for 10 clocks, release, then settle.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    btn_mode = v.m; btn_up = v.u; btn_down = v.d;
    if (v.ev) push(cyc + LAT, v.mode, v.up, v.down);
    repeat (10) @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (12) @(negedge clk);
    check(name, mode, v.mode);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[16];
    vec_t vm;
    int   t0, e0, r, s0, last, sc0;

    vt[0]  = mk(0, 1, 0, 0, 2'd0, 0, 0); // up in RUN ignored
    vt[1]  = mk(1, 0, 0, 1, 2'd1, 0, 0);
    vt[2]  = mk(0, 1, 0, 1, 2'd1, 1, 0);
    vt[3]  = mk(0, 0, 1, 1, 2'd1, 0, 1);
    vt[4]  = mk(1, 0, 0, 1, 2'd2, 0, 0);
    vt[5]  = mk(0, 1, 0, 1, 2'd2, 1, 0);
    vt[6]  = mk(0, 1, 1, 0, 2'd2, 0, 0); // simultaneous up+down ignored
    vt[7]  = mk(1, 1, 0, 1, 2'd0, 0, 0); // mode wins, no strobe
    vt[8]  = mk(1, 0, 0, 1, 2'd1, 0, 0);
    vt[9]  = mk(1, 0, 0, 1, 2'd2, 0, 0);
    vt[10] = mk(0, 0, 1, 1, 2'd2, 0, 1);
    vt[11] = mk(1, 0, 0, 1, 2'd0, 0, 0);
    vt[12] = mk(0, 0, 1, 0, 2'd0, 0, 0); // down in RUN ignored
    vt[13] = mk(1, 0, 0, 1, 2'd1, 0, 0);
    vt[14] = mk(1, 0, 1, 1, 2'd2, 0, 0); // mode wins over down
    vt[15] = mk(1, 0, 0, 1, 2'd0, 0, 0);
    vm     = mk(1, 0, 0, 1, 2'd1, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_mode", mode, 0);
    check("reset_min_ena", min_set_ena, 0);
    check("reset_hr_ena", hr_set_ena, 0);
    check("reset_up", up, 0);
    check("reset_down", down, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vt[i]) apply(vt[i], $sformatf("vec%0d_mode", i));

    // Glitchy up in SET_MIN: no strobe while toggling, one once stable.
    apply(vm, "glitch_enter");
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      btn_up = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btn_up = 1'b1;
    push(cyc + LAT, 2'd1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    vm.mode = 2'd2; apply(vm, "glitch_exit1");
    vm.mode = 2'd0; apply(vm, "glitch_exit2");

    // Idle timeout: RUN returns exactly TMO clocks after entry.
    @(negedge clk);
    btn_mode = 1'b1; t0 = cyc; e0 = t0 + LAT;
    push(e0, 2'd1, 1'b0, 1'b0);
    push(e0 + TMO, 2'd0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    wait_until(e0 + TMO + 5);
    check("timeout_mode", mode, 0);

    // A press at clock 50 after entry restarts the timeout.
    @(negedge clk);
    btn_mode = 1'b1; t0 = cyc; e0 = t0 + LAT;
    push(e0, 2'd1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    wait_until(e0 + 50 - LAT);
    btn_up = 1'b1;
    push(e0 + 50, 2'd1, 1'b1, 1'b0);
    push(e0 + 50 + TMO, 2'd0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    btn_up = 1'b0;
    wait_until(e0 + 50 + TMO - 3);
    check("timeout_delayed_still_set", mode, 1);
    wait_until(e0 + 50 + TMO + 5);
    check("timeout_delayed_mode", mode, 0);

    // Held up button in SET_MIN.
    @(negedge clk);
    btn_mode = 1'b1; t0 = cyc; e0 = t0 + LAT;
    push(e0, 2'd1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    wait_until(e0 + 5);
    @(negedge clk);
    sc0 = strobe_cnt;
    btn_up = 1'b1; r = cyc; s0 = r + LAT;
    push(s0, 2'd1, 1'b1, 1'b0);
`ifdef TIME_SET_AUTO_REPEAT_EN
    for (int k = RDLY; k <= 40; k += RPER) push(s0 + k, 2'd1, 1'b1, 1'b0);
    last = s0 + 40;
`else
    last = s0;
`endif
    push(last + TMO, 2'd0, 1'b0, 1'b0);
    wait_until(r + 44);
    btn_up = 1'b0;
    wait_until(s0 + 50);
    check("held_mode_no_timeout", mode, 1);
`ifdef TIME_SET_AUTO_REPEAT_EN
    check("held_strobe_count", strobe_cnt - sc0, 8);
`else
    check("held_strobe_count", strobe_cnt - sc0, 1);
`endif
    wait_until(last + TMO + 5);
    check("held_final_mode", mode, 0);

    // Reset mid-SET_HOUR with an up strobe in flight.
    vm.mode = 2'd1; apply(vm, "rst_enter1");
    vm.mode = 2'd2; apply(vm, "rst_enter2");
    @(negedge clk);
    btn_up = 1'b1; r = cyc;
    wait_until(r + LAT - 1);
    #2;
    rst = 1'b1;
    btn_up = 1'b0;
    #1;
    check("midrst_mode", mode, 0);
    check("midrst_hr_ena", hr_set_ena, 0);
    check("midrst_min_ena", min_set_ena, 0);
    check("midrst_up", up, 0);
    check("midrst_down", down, 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("postrst_mode", mode, 0);
    check("postrst_ena", {min_set_ena, hr_set_ena}, 0);
    check("postrst_strobes", {up, down}, 0);

    check("scoreboard_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
